alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the combinational 6502 ALU.
- Adds a start/done handshake, 6502 decimal (BCD) add/subtract, barrel-free multi-bit shifts and rotate-through-carry.
- Sits between the control unit and the register file/flag register. The control unit issues one operation, then waits for done.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be a multiple of 4 and >= 4.
- CNT_W, $clog2(WIDTH)+1, width of the shift-count field taken from input_b[CNT_W-1:0].

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- operation  input  control_signals::alu_op_t  operation select
- decimal_mode  input  1  BCD mode for ALU_ADD/ALU_SUB; ignored for other ops
- carry_in  input  1  carry / not-borrow / rotate bit
- input_a  input  WIDTH  operand A, or value to shift
- input_b  input  WIDTH  operand B; for shifts, input_b[CNT_W-1:0] is the count
- busy  output  1  high from the edge after an accepted start until done
- done  output  1  one-cycle pulse when results update
- alu_out  output  WIDTH  registered result; held until the next done
- carry_out, overflow_out, zero_out, negative_out  output  1 each  registered flags; held with alu_out

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy=0, done=0, alu_out=0, all flags=0.
  - Reset mid-operation abandons the operation with no done pulse.
- States: IDLE, SHIFT, BCD.
- Operand latching and timing:
  - Start accepted in IDLE at edge 0: operands, operation, decimal_mode and carry_in are latched.
  - Each later edge performs one step. The final step writes the outputs and pulses done.
  - start while busy is ignored and not queued.
  - start on the same cycle done is high is accepted, because the state is already IDLE.
- Single-step ops, done at edge 1:
  - ALU_ADD (binary): {C,R} = A + B + carry_in.
  - ALU_SUB (binary): {C,R} = A + ~B + carry_in. C=1 means no borrow, per 6502 SBC.
  - ALU_AND, ALU_OR, ALU_XOR: bitwise. carry_out = latched carry_in, V=0.
  - Shift or rotate with count 0: R=A, C=carry_in, V=0.
- Overflow (binary ADD/SUB): V = (A[MSB]==B'[MSB]) && (R[MSB]!=A[MSB]), where B' = B for add and ~B for sub.
- N/Z for all ops: N = R[WIDTH-1], Z = (R==0).
- SHIFT state:
  - n = min(count, WIDTH). Done is at edge n.
  - One bit per cycle; carry holds the last bit shifted out.
  - ALU_SHIFT_LEFT shifts in 0 at bit 0.
  - ALU_SHIFT_RIGHT shifts in 0 at the MSB.
  - ALU_ROTATE_LEFT and ALU_ROTATE_RIGHT rotate through a WIDTH+1-bit ring {C,R}, with C seeded from carry_in.
  - V=0 for all shifts and rotates.
- BCD state (ADD/SUB with decimal_mode=1):
  - One nibble per cycle, LSB first; done at edge WIDTH/4.
  - Add: s = a_n + b_n + c. If s > 9: s += 6, c = 1; else c = 0.
  - Sub: d = a_n - b_n - !c. If d < 0: d = (d - 6) mod 16, c = 0 (borrow); else c = 1.
  - C = final c. N/Z are taken from the BCD result.
  - V is the binary-mode V computed on the latched operands.
  - Non-BCD digits are processed by the same rule; no error flag.
- Outputs change only on done edges; done never lasts more than 1 cycle.

Decomposition:
- Extend the control_signals package:
  - Add ALU_OR, ALU_XOR, ALU_SHIFT_RIGHT, ALU_ROTATE_LEFT and ALU_ROTATE_RIGHT to alu_op_t.
  - Existing encodings for ALU_ADD, ALU_SUB, ALU_AND and ALU_SHIFT_LEFT are unchanged.
  - Add alu_seq_state_t (IDLE, SHIFT, BCD) to the same package.
- One sub-module: bcd_digit_step, a combinational nibble add/sub with correction. Inputs are a_n, b_n, c and sub; outputs are r_n and c_out.

Test Plan:
- ADD, binary: carry_in=1, A=0x05, B=0x05 -> done at edge 1, alu_out=0x0B, C=0, V=0, Z=0, N=0. Then A=0x50, B=0x50, carry_in=0 -> 0xA0, V=1, N=1.
- SUB, binary: carry_in=1, A=0x04, B=0x05 -> 0xFF, C=0, N=1. Then A=0x05, B=0x05 -> 0x00, C=1, Z=1.
- Decimal: ADD A=0x58, B=0x46, carry_in=1 -> done at edge 2, 0x05, C=1. Decimal SUB A=0x12, B=0x21, carry_in=1 -> 0x91, C=0.
- Shifts:
  - SHIFT_LEFT A=0xC3, count=3 -> busy for 3 cycles, done at edge 3, 0x18, C=0.
  - ROTATE_RIGHT A=0x01, carry_in=1, count=1 -> 0x80, C=1.
  - Count=0 -> 0xC3, done at edge 1.
- Handshake: second start pulsed while busy -> ignored, exactly one done. start held high through done -> the back-to-back op is accepted immediately.
- Reset: rst_n low during a count=8 shift -> immediately busy=0, done=0, alu_out=0, flags=0; no done afterwards.

Source files
------------

// File: rtl/control_signals_pkg.sv
//----------------------------------------------------------------------------
// Module      : control_signals (package)
// Description : ALU operation encodings and sequential-ALU state encoding
//               shared by the control unit and alu_seq.
// Revision    : 1.0 - initial sequential ALU release
//----------------------------------------------------------------------------
`default_nettype none

package control_signals;

  // Original four encodings kept at their historical values.
  typedef enum logic [3:0] {
    ALU_ADD          = 4'd0,
    ALU_SUB          = 4'd1,
    ALU_AND          = 4'd2,
    ALU_SHIFT_LEFT   = 4'd3,
    ALU_OR           = 4'd4,
    ALU_XOR          = 4'd5,
    ALU_SHIFT_RIGHT  = 4'd6,
    ALU_ROTATE_LEFT  = 4'd7,
    ALU_ROTATE_RIGHT = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    BCD   = 2'd2
  } alu_seq_state_t;

  // True for the four one-bit-per-cycle shift/rotate operations.
  function automatic logic is_shift_op(input alu_op_t op);
    return (op == ALU_SHIFT_LEFT)  || (op == ALU_SHIFT_RIGHT) ||
           (op == ALU_ROTATE_LEFT) || (op == ALU_ROTATE_RIGHT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_bcd_digit_step.sv
//----------------------------------------------------------------------------
// Module      : bcd_digit_step
// Description : Combinational 6502-style decimal add/subtract of one nibble,
//               including the +6 / -6 digit correction.
// Revision    : 1.0 - initial sequential ALU release
//----------------------------------------------------------------------------
`default_nettype none

module bcd_digit_step
  import control_signals::*;
(
  input  logic [3:0] a_n,
  input  logic [3:0] b_n,
  input  logic       c,
  input  logic       sub,
  output logic [3:0] r_n,
  output logic       c_out
);

  logic [4:0] sum_w;
  logic [4:0] diff_w;

  // Digit sum/difference with decimal correction; c is carry or not-borrow.
  always_comb begin
    sum_w  = {1'b0, a_n} + {1'b0, b_n} + {4'b0000, c};
    diff_w = {1'b0, a_n} - {1'b0, b_n} - {4'b0000, ~c};
    r_n    = sum_w[3:0];
    c_out  = 1'b0;
    if (sub) begin
      if (diff_w[4]) begin
        // Negative difference: borrow out, wrap the digit down by 6.
        r_n   = diff_w[3:0] - 4'd6;
        c_out = 1'b0;
      end else begin
        r_n   = diff_w[3:0];
        c_out = 1'b1;
      end
    end else if (sum_w > 5'd9) begin
      r_n   = sum_w[3:0] + 4'd6;
      c_out = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
//----------------------------------------------------------------------------
// Module      : alu_seq
// Description : Multi-cycle 6502 ALU with start/done handshake, decimal
//               add/subtract one nibble per cycle and one-bit-per-cycle
//               shifts/rotates through carry.
// Revision    : 1.0 - initial sequential ALU release
//----------------------------------------------------------------------------
`default_nettype none

module alu_seq
  import control_signals::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  control_signals::alu_op_t operation,
  input  logic                   decimal_mode,
  input  logic                   carry_in,
  input  logic [WIDTH-1:0]       input_a,
  input  logic [WIDTH-1:0]       input_b,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       alu_out,
  output logic                   carry_out,
  output logic                   overflow_out,
  output logic                   zero_out,
  output logic                   negative_out
);

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] NIB_CNT   = CNT_W'(WIDTH / 4);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT  = '0;

  // Working registers; a_q doubles as the shifting value and BCD result.
  alu_seq_state_t   state_q, state_d;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Result/flag registers, only updated on a done edge.
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;

  // Combinational helpers.
  logic [WIDTH-1:0] bin_b_in_w, bin_r_in_w;
  logic             bin_ovf_in_w;
  logic [CNT_W-1:0] cnt_in_w, cnt_sat_w;
  logic [WIDTH-1:0] exec_b_w;
  logic [WIDTH:0]   exec_sum_w;
  logic [WIDTH-1:0] exec_r_w;
  logic             exec_c_w, exec_v_w;
  logic [WIDTH-1:0] step_a_w;
  logic             step_c_w;
  logic [3:0]       digit_r_w;
  logic             digit_c_w;
  logic [WIDTH-1:0] bcd_next_w;
  logic             fin_en_w;
  logic [WIDTH-1:0] fin_r_w;
  logic             fin_c_w, fin_v_w;

  bcd_digit_step u_bcd_digit_step (
    .a_n   (a_q[3:0]),
    .b_n   (b_q[3:0]),
    .c     (c_q),
    .sub   (op_q == ALU_SUB),
    .r_n   (digit_r_w),
    .c_out (digit_c_w)
  );

  // New digit enters at the top while the consumed low nibble drops out.
  generate
    if (WIDTH == 4) begin : g_bcd_narrow
      assign bcd_next_w = digit_r_w;
    end else begin : g_bcd_wide
      assign bcd_next_w = {digit_r_w, a_q[WIDTH-1:4]};
    end
  endgenerate

  // Binary overflow from raw inputs, kept for decimal mode where a_q is reused.
  always_comb begin
    bin_b_in_w   = (operation == ALU_SUB) ? ~input_b : input_b;
    bin_r_in_w   = input_a + bin_b_in_w + {{(WIDTH-1){1'b0}}, carry_in};
    bin_ovf_in_w = (input_a[WIDTH-1] == bin_b_in_w[WIDTH-1]) &&
                   (bin_r_in_w[WIDTH-1] != input_a[WIDTH-1]);
    cnt_in_w     = input_b[CNT_W-1:0];
    cnt_sat_w    = (cnt_in_w > MAX_CNT) ? MAX_CNT : cnt_in_w;
  end

  // Single-step result for binary/logic ops and zero-count shifts.
  always_comb begin
    exec_b_w   = (op_q == ALU_SUB) ? ~b_q : b_q;
    exec_sum_w = {1'b0, a_q} + {1'b0, exec_b_w} + {{WIDTH{1'b0}}, c_q};
    exec_r_w   = a_q;
    exec_c_w   = c_q;
    exec_v_w   = 1'b0;
    case (op_q)
      ALU_ADD, ALU_SUB: begin
        exec_r_w = exec_sum_w[WIDTH-1:0];
        exec_c_w = exec_sum_w[WIDTH];
        exec_v_w = v_q;
      end
      ALU_AND: exec_r_w = a_q & b_q;
      ALU_OR:  exec_r_w = a_q | b_q;
      ALU_XOR: exec_r_w = a_q ^ b_q;
      default: exec_r_w = a_q;
    endcase
  end

  // One bit of shift or rotate through the {C,R} ring.
  always_comb begin
    step_a_w = a_q;
    step_c_w = c_q;
    case (op_q)
      ALU_SHIFT_LEFT: begin
        step_a_w = {a_q[WIDTH-2:0], 1'b0};
        step_c_w = a_q[WIDTH-1];
      end
      ALU_SHIFT_RIGHT: begin
        step_a_w = {1'b0, a_q[WIDTH-1:1]};
        step_c_w = a_q[0];
      end
      ALU_ROTATE_LEFT: begin
        step_a_w = {a_q[WIDTH-2:0], c_q};
        step_c_w = a_q[WIDTH-1];
      end
      ALU_ROTATE_RIGHT: begin
        step_a_w = {c_q, a_q[WIDTH-1:1]};
        step_c_w = a_q[0];
      end
      default: begin
        step_a_w = a_q;
        step_c_w = c_q;
      end
    endcase
  end

  // Next-state and result-update logic; SHIFT also serves single-step ops.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    v_d       = v_q;
    cnt_d     = cnt_q;
    alu_out_d = alu_out_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    fin_en_w  = 1'b0;
    fin_r_w   = exec_r_w;
    fin_c_w   = exec_c_w;
    fin_v_w   = exec_v_w;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = operation;
          a_d  = input_a;
          b_d  = input_b;
          c_d  = carry_in;
          v_d  = bin_ovf_in_w;
          if (((operation == ALU_ADD) || (operation == ALU_SUB)) && decimal_mode) begin
            state_d = BCD;
            cnt_d   = NIB_CNT;
          end else begin
            state_d = SHIFT;
            cnt_d   = cnt_sat_w;
          end
        end
      end
      SHIFT: begin
        if (is_shift_op(op_q) && (cnt_q != ZERO_CNT)) begin
          a_d   = step_a_w;
          c_d   = step_c_w;
          cnt_d = cnt_q - ONE_CNT;
          if (cnt_q == ONE_CNT) begin
            fin_en_w = 1'b1;
            fin_r_w  = step_a_w;
            fin_c_w  = step_c_w;
            fin_v_w  = 1'b0;
          end
        end else begin
          fin_en_w = 1'b1;
        end
      end
      BCD: begin
        a_d   = bcd_next_w;
        b_d   = b_q >> 4;
        c_d   = digit_c_w;
        cnt_d = cnt_q - ONE_CNT;
        if (cnt_q == ONE_CNT) begin
          fin_en_w = 1'b1;
          fin_r_w  = bcd_next_w;
          fin_c_w  = digit_c_w;
          fin_v_w  = v_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin_en_w) begin
      state_d   = IDLE;
      alu_out_d = fin_r_w;
      carry_d   = fin_c_w;
      ovf_d     = fin_v_w;
      zero_d    = (fin_r_w == '0);
      neg_d     = fin_r_w[WIDTH-1];
      done_d    = 1'b1;
    end
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= ALU_ADD;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      cnt_q     <= '0;
      alu_out_q <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      v_q       <= v_d;
      cnt_q     <= cnt_d;
      alu_out_q <= alu_out_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign alu_out      = alu_out_q;
  assign carry_out    = carry_q;
  assign overflow_out = ovf_q;
  assign zero_out     = zero_q;
  assign negative_out = neg_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
//----------------------------------------------------------------------------
// Module      : tb_alu_seq
// Description : Scoreboard bench for alu_seq (WIDTH=8) with directed vectors.
// Revision    : 1.0 - initial sequential ALU release
//----------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;
  import control_signals::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  alu_op_t    operation = ALU_ADD;
  logic       decimal_mode = 1'b0;
  logic       carry_in = 1'b0;
  logic [7:0] input_a = 8'h00;
  logic [7:0] input_b = 8'h00;
  logic       busy, done;
  logic [7:0] alu_out;
  logic       carry_out, overflow_out, zero_out, negative_out;

  typedef struct {
    logic [7:0] r;
    logic       c, v, z, n;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .operation    (operation),
    .decimal_mode (decimal_mode),
    .carry_in     (carry_in),
    .input_a      (input_a),
    .input_b      (input_b),
    .busy         (busy),
    .done         (done),
    .alu_out      (alu_out),
    .carry_out    (carry_out),
    .overflow_out (overflow_out),
    .zero_out     (zero_out),
    .negative_out (negative_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] r, input logic c, v, z, n, input int due);
    exp_t e;
    e.r = r; e.c = c; e.v = v; e.z = z; e.n = n; e.due = due;
    return e;
  endfunction

  // Monitor: count edges, pop and compare whenever done is presented.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", done, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_edge", cyc, mon_e.due);
        chk("alu_out", alu_out, mon_e.r);
        chk("carry_out", carry_out, mon_e.c);
        chk("overflow_out", overflow_out, mon_e.v);
        chk("zero_out", zero_out, mon_e.z);
        chk("negative_out", negative_out, mon_e.n);
        chk("busy_at_done", busy, 1'b0);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic drive(input alu_op_t op, input logic dec, cin, input logic [7:0] a, b);
    operation = op; decimal_mode = dec; carry_in = cin; input_a = a; input_b = b;
  endtask

  task automatic issue(input alu_op_t op, input logic dec, cin, input logic [7:0] a, b,
                       input int lat, input logic [7:0] r, input logic c, v, z, n);
    @(negedge clk);
    drive(op, dec, cin, a, b);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back(mk(r, c, v, z, n, cyc + lat));
    chk("busy_after_start", busy, 1'b1);
    wait_idle();
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_alu_out"}, alu_out, 8'h00);
    chk({tag, "_flags"}, {carry_out, overflow_out, zero_out, negative_out}, 4'b0000);
  endtask

  initial begin
    int e0;
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    rst_n = 1'b1;

    // op, dec, cin, A, B, latency, R, C, V, Z, N
    issue(ALU_ADD,          0, 1, 8'h05, 8'h05, 1, 8'h0B, 0, 0, 0, 0);
    issue(ALU_ADD,          0, 0, 8'h50, 8'h50, 1, 8'hA0, 0, 1, 0, 1);
    issue(ALU_SUB,          0, 1, 8'h04, 8'h05, 1, 8'hFF, 0, 0, 0, 1);
    issue(ALU_SUB,          0, 1, 8'h05, 8'h05, 1, 8'h00, 1, 0, 1, 0);
    issue(ALU_ADD,          1, 1, 8'h58, 8'h46, 2, 8'h05, 1, 1, 0, 0);
    issue(ALU_SUB,          1, 1, 8'h12, 8'h21, 2, 8'h91, 0, 0, 0, 1);
    issue(ALU_ADD,          1, 0, 8'h99, 8'h01, 2, 8'h00, 1, 0, 1, 0);
    issue(ALU_AND,          0, 1, 8'hF0, 8'h3C, 1, 8'h30, 1, 0, 0, 0);
    issue(ALU_OR,           0, 0, 8'hF0, 8'h0F, 1, 8'hFF, 0, 0, 0, 1);
    issue(ALU_XOR,          1, 1, 8'hAA, 8'hAA, 1, 8'h00, 1, 0, 1, 0);
    issue(ALU_SHIFT_LEFT,   0, 0, 8'hC3, 8'h03, 3, 8'h18, 0, 0, 0, 0);
    issue(ALU_ROTATE_RIGHT, 0, 1, 8'h01, 8'h01, 1, 8'h80, 1, 0, 0, 1);
    issue(ALU_SHIFT_LEFT,   0, 0, 8'hC3, 8'h00, 1, 8'hC3, 0, 0, 0, 1);
    issue(ALU_ROTATE_LEFT,  0, 1, 8'hC3, 8'h00, 1, 8'hC3, 1, 0, 0, 1);
    issue(ALU_SHIFT_RIGHT,  0, 0, 8'h81, 8'h01, 1, 8'h40, 1, 0, 0, 0);
    issue(ALU_ROTATE_LEFT,  0, 0, 8'h80, 8'h02, 2, 8'h01, 0, 0, 0, 0);
    issue(ALU_SHIFT_LEFT,   0, 0, 8'hFF, 8'h0F, 8, 8'h00, 1, 0, 1, 0);

    // Second start while busy must be dropped.
    @(negedge clk);
    drive(ALU_SHIFT_LEFT, 0, 0, 8'hC3, 8'h03);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back(mk(8'h18, 0, 0, 0, 0, cyc + 3));
    @(negedge clk);
    drive(ALU_ADD, 0, 0, 8'h01, 8'h01);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ignore", busy, 1'b1);
    wait_idle();
    repeat (4) @(negedge clk);

    // start held through done: next op accepted on the edge after done.
    @(negedge clk);
    drive(ALU_ADD, 0, 1, 8'h05, 8'h05);
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    sb.push_back(mk(8'h0B, 0, 0, 0, 0, e0 + 1));
    sb.push_back(mk(8'hFC, 0, 0, 0, 1, e0 + 3));
    drive(ALU_XOR, 0, 0, 8'h0F, 8'hF3);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_back_to_back", busy, 1'b1);
    wait_idle();

    // Reset mid-way through a long rotate.
    @(negedge clk);
    drive(ALU_ROTATE_RIGHT, 0, 0, 8'h5A, 8'h08);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("midop_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_after_reset", busy, 1'b0);
    chk("no_done_after_reset", alu_out, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
